// File: rtl/dmem_arb_pkg.sv
// Shared types and default sizing for the data-memory arbiter.
package dmem_arb_pkg;

    localparam int unsigned DEF_AW        = 8;
    localparam int unsigned DEF_DW        = 8;
    localparam int unsigned DEF_MAX_WAIT  = 4;
    localparam int unsigned DEF_BURST_MAX = 16;
    localparam int unsigned WAIT_W        = 4;
    localparam int unsigned BURST_W       = 8;

    typedef enum logic [1:0] {S_CORE_PRI, S_HOST_BURST, S_CORE_SLOT} arb_state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_CORE, OWN_HOST} owner_t;

endpackage

// File: rtl/arb_sat_ctr.sv
// Saturating up-counter with synchronous clear; used for the wait, burst and stats counters.
module arb_sat_ctr #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned MAX   = 4
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count,
    output logic             at_max
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    assign at_max = (count == MAX_V);

    always_ff @(posedge CLK) begin
        if (reset || clr) begin
            count <= '0;
        end else if (inc && !at_max) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Core/host arbiter for the single-port data memory: core priority, bounded host wait, lockable host bursts.
// Define DMEM_ARB_STATS_EN to add the stat_conflicts / stat_core_stalls counters.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned AW        = DEF_AW,
    parameter int unsigned DW        = DEF_DW,
    parameter int unsigned MAX_WAIT  = DEF_MAX_WAIT,
    parameter int unsigned BURST_MAX = DEF_BURST_MAX
) (
    input  logic          CLK,
    input  logic          reset,
    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic          core_ready,
    output logic [DW-1:0] core_rdata,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    input  logic          host_lock,
    output logic          host_ready,
    output logic [DW-1:0] host_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    output logic          mem_re,
    input  logic [DW-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [15:0]   stat_conflicts,
    output logic [15:0]   stat_core_stalls
`endif
);

    arb_state_t          state;
    owner_t              owner;
    logic [WAIT_W-1:0]   wait_ctr;
    logic                wait_full;
    logic [BURST_W-1:0]  burst_ctr;
    logic                burst_full;
    logic                burst_last;
    logic                burst_inc;
    logic                burst_clr;
    logic                unused_ok;

    assign burst_last = (burst_ctr == BURST_W'(BURST_MAX - 1));

    always_comb begin
        owner = OWN_NONE;
        if (!reset) begin
            case (state)
                S_CORE_PRI: begin
                    if (host_req && wait_full) owner = OWN_HOST;
                    else if (core_req)         owner = OWN_CORE;
                    else if (host_req)         owner = OWN_HOST;
                end
                S_HOST_BURST: begin
                    if (host_req && !burst_full) owner = OWN_HOST;
                    else if (core_req)           owner = OWN_CORE;
                end
                S_CORE_SLOT: begin
                    if (core_req) owner = OWN_CORE;
                end
                default: owner = OWN_NONE;
            endcase
        end
    end

    assign core_ready = (owner == OWN_CORE);
    assign host_ready = (owner == OWN_HOST);
    assign core_rdata = core_ready ? mem_rdata : '0;
    assign host_rdata = host_ready ? mem_rdata : '0;

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        case (owner)
            OWN_CORE: begin
                mem_addr  = core_addr;
                mem_wdata = core_wdata;
                mem_we    = core_we;
                mem_re    = !core_we;
            end
            OWN_HOST: begin
                mem_addr  = host_addr;
                mem_wdata = host_wdata;
                mem_we    = host_we;
                mem_re    = !host_we;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state <= S_CORE_PRI;
        end else begin
            case (state)
                S_CORE_PRI: begin
                    if (host_ready && host_lock)
                        state <= (BURST_MAX == 1) ? S_CORE_SLOT : S_HOST_BURST;
                end
                S_HOST_BURST: begin
                    if (host_ready && burst_last)    state <= S_CORE_SLOT;
                    else if (!(host_req && host_lock)) state <= S_CORE_PRI;
                end
                S_CORE_SLOT: state <= S_CORE_PRI;
                default:     state <= S_CORE_PRI;
            endcase
        end
    end

    // Burst count starts at 1 with the opening grant in S_CORE_PRI and is zeroed on any burst exit.
    assign burst_inc = host_ready && ((state == S_HOST_BURST) || (state == S_CORE_PRI && host_lock));
    assign burst_clr = (state == S_CORE_SLOT) || (state == S_HOST_BURST && !(host_req && host_lock));

    arb_sat_ctr #(.WIDTH(WAIT_W), .MAX(MAX_WAIT)) u_wait_ctr (
        .CLK    (CLK),
        .reset  (reset),
        .inc    (host_req && !host_ready),
        .clr    (host_ready || !host_req),
        .count  (wait_ctr),
        .at_max (wait_full)
    );

    arb_sat_ctr #(.WIDTH(BURST_W), .MAX(BURST_MAX)) u_burst_ctr (
        .CLK    (CLK),
        .reset  (reset),
        .inc    (burst_inc),
        .clr    (burst_clr),
        .count  (burst_ctr),
        .at_max (burst_full)
    );

`ifdef DMEM_ARB_STATS_EN
    logic conf_full;
    logic stall_full;

    arb_sat_ctr #(.WIDTH(16), .MAX(16'hFFFF)) u_stat_conflicts (
        .CLK    (CLK),
        .reset  (reset),
        .inc    (core_req && host_req),
        .clr    (1'b0),
        .count  (stat_conflicts),
        .at_max (conf_full)
    );

    arb_sat_ctr #(.WIDTH(16), .MAX(16'hFFFF)) u_stat_core_stalls (
        .CLK    (CLK),
        .reset  (reset),
        .inc    (core_req && !core_ready),
        .clr    (1'b0),
        .count  (stat_core_stalls),
        .at_max (stall_full)
    );

    assign unused_ok = ^{wait_ctr, conf_full, stall_full};
`else
    assign unused_ok = ^wait_ctr;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter; stats checks compile in with DMEM_ARB_STATS_EN.
module tb_dmem_arbiter;

    localparam int unsigned MAX_WAIT  = 4;
    localparam int unsigned BURST_MAX = 16;

    logic       CLK;
    logic       reset;
    logic       core_req, core_we, core_ready;
    logic [7:0] core_addr, core_wdata, core_rdata;
    logic       host_req, host_we, host_lock, host_ready;
    logic [7:0] host_addr, host_wdata, host_rdata;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    logic       mem_we, mem_re;
`ifdef DMEM_ARB_STATS_EN
    logic [15:0] stat_conflicts, stat_core_stalls;
`endif

    dmem_arbiter #(.AW(8), .DW(8), .MAX_WAIT(MAX_WAIT), .BURST_MAX(BURST_MAX)) dut (
        .CLK        (CLK),
        .reset      (reset),
        .core_req   (core_req),
        .core_we    (core_we),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_ready (core_ready),
        .core_rdata (core_rdata),
        .host_req   (host_req),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_lock  (host_lock),
        .host_ready (host_ready),
        .host_rdata (host_rdata),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_re     (mem_re),
        .mem_rdata  (mem_rdata)
`ifdef DMEM_ARB_STATS_EN
        ,
        .stat_conflicts   (stat_conflicts),
        .stat_core_stalls (stat_core_stalls)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic [7:0] mem [256];
    logic [7:0] shadow [256];

    assign mem_rdata = mem[mem_addr];

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        forever begin
            @(posedge CLK);
            if (mem_we) mem[mem_addr] = mem_wdata;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic       cr, hr, mwe, mre;
        logic [7:0] crd, hrd, ma, mwd;
    } exp_t;

    exp_t sb[$];

    int          m_state = 0;   // 0 core-priority, 1 host burst, 2 core slot
    int unsigned m_wait  = 0;
    int unsigned m_burst = 0;
    int          e_owner;       // 0 none, 1 core, 2 host
    logic        o_cr, o_hr, o_mwe;
    logic [7:0]  o_crd;

    task automatic cycle(input logic rst,
                         input logic cr, input logic cwe, input logic [7:0] ca, input logic [7:0] cwd,
                         input logic hr, input logic hwe, input logic [7:0] ha, input logic [7:0] hwd,
                         input logic hl);
        exp_t e;
        reset = rst;
        core_req = cr; core_we = cwe; core_addr = ca; core_wdata = cwd;
        host_req = hr; host_we = hwe; host_addr = ha; host_wdata = hwd; host_lock = hl;

        e_owner = 0;
        if (!rst) begin
            case (m_state)
                0: e_owner = (hr && m_wait == MAX_WAIT) ? 2 : cr ? 1 : hr ? 2 : 0;
                1: e_owner = hr ? 2 : cr ? 1 : 0;
                default: e_owner = cr ? 1 : 0;
            endcase
        end
        e.cr  = (e_owner == 1);
        e.hr  = (e_owner == 2);
        e.crd = (e_owner == 1) ? shadow[ca] : 8'h00;
        e.hrd = (e_owner == 2) ? shadow[ha] : 8'h00;
        e.ma  = (e_owner == 1) ? ca : (e_owner == 2) ? ha : 8'h00;
        e.mwd = (e_owner == 1) ? cwd : (e_owner == 2) ? hwd : 8'h00;
        e.mwe = (e_owner == 1 && cwe) || (e_owner == 2 && hwe);
        e.mre = (e_owner == 1 && !cwe) || (e_owner == 2 && !hwe);
        sb.push_back(e);

        @(negedge CLK);
        e = sb.pop_front();
        o_cr = core_ready; o_hr = host_ready; o_crd = core_rdata; o_mwe = mem_we;
        check("core_ready", core_ready, e.cr);
        check("host_ready", host_ready, e.hr);
        check("core_rdata", core_rdata, e.crd);
        check("host_rdata", host_rdata, e.hrd);
        check("mem_addr",   mem_addr,   e.ma);
        check("mem_wdata",  mem_wdata,  e.mwd);
        check("mem_we",     mem_we,     e.mwe);
        check("mem_re",     mem_re,     e.mre);

        @(posedge CLK);
        if (e.mwe) shadow[e.ma] = e.mwd;
        if (rst) begin
            m_state = 0; m_wait = 0; m_burst = 0;
        end else begin
            if (e_owner == 2 || !hr) m_wait = 0;
            else if (m_wait < MAX_WAIT) m_wait++;
            case (m_state)
                0: if (e_owner == 2 && hl) begin
                    m_burst = 1;
                    m_state = (BURST_MAX == 1) ? 2 : 1;
                end
                1: if (e_owner == 2 && m_burst + 1 == BURST_MAX) begin
                    m_state = 2; m_burst = 0;
                end else if (!(hr && hl)) begin
                    m_state = 0; m_burst = 0;
                end else if (e_owner == 2) begin
                    m_burst++;
                end
                default: begin m_state = 0; m_burst = 0; end
            endcase
        end
        #1;
    endtask

    task automatic idle(input logic rst);
        cycle(rst, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int unsigned n, f, run, gap, budget;
        logic [1:0] seq[$];

        for (int i = 0; i < 256; i++) shadow[i] = 8'h00;
        reset = 1'b1;
        core_req = 0; core_we = 0; core_addr = 0; core_wdata = 0;
        host_req = 0; host_we = 0; host_addr = 0; host_wdata = 0; host_lock = 0;
        @(posedge CLK); #1;

        idle(1);
        check("rst_core_ready", o_cr, 1'b0);
        check("rst_host_ready", o_hr, 1'b0);
        idle(0);

        // Host preload, then core load of the preloaded byte.
        cycle(0, 0, 0, 8'h00, 8'h00, 1, 1, 8'h10, 8'h5A, 0);
        cycle(0, 1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 0);
        check("t1_core_ready", o_cr, 1'b1);
        check("t1_core_rdata", o_crd, 8'h5A);

        // Host store waits MAX_WAIT cycles behind continuous core traffic.
        idle(1);
        for (int i = 1; i <= 5; i++) begin
            cycle(0, 1, 0, 8'h10, 8'h00, 1, 1, 8'h20, 8'hC3, 0);
            check("t2_host_ready", o_hr, (i == 5));
            check("t2_core_ready", o_cr, (i != 5));
        end
`ifdef DMEM_ARB_STATS_EN
        check("t6_conflicts", stat_conflicts, 16'd5);
        check("t6_core_stalls", stat_core_stalls, 16'd1);
`endif
        idle(1);
        check("t2_mem20", mem[8'h20], 8'hC3);
`ifdef DMEM_ARB_STATS_EN
        check("t6_conflicts_rst", stat_conflicts, 16'd0);
        check("t6_core_stalls_rst", stat_core_stalls, 16'd0);
`endif

        // Idle bus, then unlocked host-only reads that must not enter a burst.
        idle(0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 8'h00, 8'h00, 1, 0, 8'h10, 8'h00, 0);
        check("t4_host_rdata_seen", o_hr, 1'b1);
        cycle(0, 1, 0, 8'h20, 8'h00, 1, 0, 8'h10, 8'h00, 0);
        check("t4_core_pri", o_cr, 1'b1);
        check("t4_core_rdata", o_crd, 8'hC3);
        idle(0);

        // Locked 20-write host burst against continuous core loads.
        n = 0; budget = 0;
        while (n < 20 && budget < 200) begin
            cycle(0, 1, 0, 8'h10, 8'h00, 1, 1, 8'(8'h40 + n), 8'(8'hA0 + n), 1);
            seq.push_back({o_hr, o_cr});
            if (e_owner == 2) n++;
            budget++;
        end
        check("t3_all_writes", (n == 20), 1'b1);
        idle(0);
        f = 0;
        while (f < seq.size() && seq[f] != 2'b10) f++;
        run = 0;
        while (f + run < seq.size() && seq[f + run] == 2'b10) run++;
        gap = 0;
        while (f + run + gap < seq.size() && seq[f + run + gap] == 2'b01) gap++;
        check("t3_first_host", 16'(f), 16'd4);
        check("t3_burst_len", 16'(run), 16'd16);
        check("t3_resume_gap", 16'(gap), 16'd4);
        check("t3_mem40", mem[8'h40], 8'hA0);
        check("t3_mem53", mem[8'h53], 8'hB3);

        // Reset in burst cycle 3 suppresses the write and abandons the burst.
        cycle(0, 0, 0, 8'h00, 8'h00, 1, 1, 8'h60, 8'h11, 1);
        cycle(0, 0, 0, 8'h00, 8'h00, 1, 1, 8'h61, 8'h22, 1);
        cycle(1, 0, 0, 8'h00, 8'h00, 1, 1, 8'h62, 8'hEE, 1);
        check("t5_rst_host_ready", o_hr, 1'b0);
        check("t5_rst_mem_we", o_mwe, 1'b0);
        check("t5_mem62", mem[8'h62], 8'h00);
        cycle(0, 1, 0, 8'h61, 8'h00, 1, 1, 8'h62, 8'hEE, 1);
        check("t5_core_first", o_cr, 1'b1);
        check("t5_core_rdata", o_crd, 8'h22);
        idle(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
